lelbc_iter_core: RTL and testbench



---
 rtl/lelbc_pkg.sv | 48 ++++
 rtl/lelbc_round.sv | 26 ++
 rtl/lelbc_iter_core.sv | 140 ++++++++++++++
 tb/tb_lelbc_iter_core.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lelbc_pkg.sv
// LELBC shared definitions: widths, rotation amounts, S-box and key-schedule step.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
// Bit numbering: the cipher labels bit 0 as the MSB, so label bit i maps to vector bit W-1-i.
package lelbc_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 128;
    localparam int ROT_F   = 5;
    localparam int ROT_K   = 61;

    // S-box entry n sits in nibble [63-4n -: 4], so the table reads left to right as index 0..F.
    localparam logic [63:0] SBOX = 64'hCE6A_4F27_983B_0D15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        return SBOX[63 - 4*int'(n) -: 4];
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[4*i +: 4] = sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] a);
        return (a << ROT_F) | (a >> (32 - ROT_F));
    endfunction

    // Key after round rnd: rotate left 61, substitute the top nibble, fold the
    // round index into label bits 59..63 (vector bits 68..64).
    function automatic logic [KEY_W-1:0] key_next(input logic [KEY_W-1:0] k, input logic [4:0] rnd);
        logic [KEY_W-1:0] r;
        r = (k << ROT_K) | (k >> (KEY_W - ROT_K));
        r[127:124] = sbox4(r[127:124]);
        r[68:64]   = r[68:64] ^ rnd;
        return r;
    endfunction

endpackage

// File: rtl/lelbc_round.sv
// One LELBC round f(X,K) on a 64-bit block using the upper 64 bits of the round key.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: x = block in, k = round-key half (label bits 0..63), y = block out.
module lelbc_round
    import lelbc_pkg::*;
(
    input  logic [BLOCK_W-1:0] x,
    input  logic [63:0]        k,
    output logic [BLOCK_W-1:0] y
);

    logic [31:0] a, b, c, d;
    logic [63:0] s;

    always_comb begin
        a = x[63:32] ^ k[63:32];
        b = rotl32(a) ^ x[31:0];
        s = sbox64({a, b});
        c = s[63:32] ^ rotl32(s[31:0]);
        d = s[31:0] ^ k[31:0];
    end

    assign y = {c, d};

endmodule

// File: rtl/lelbc_iter_core.sv
// Iterative LELBC encryptor: UNROLL chained rounds per clock with on-the-fly key schedule.
// Latency: ROUNDS/UNROLL cycles from accept edge to out_valid.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk/rst_n (async active-low), in_valid/in_ready/in_data/in_key plaintext side,
//        out_valid/out_ready/out_data ciphertext side, busy = rounds in progress.
// Build option: define LELBC_ABORT_EN to add an abort input that drops RUN/DONE back to IDLE.
module lelbc_iter_core
    import lelbc_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int UNROLL = 1,
    parameter int CNT_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [KEY_W-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
`ifdef LELBC_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy
);

    if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("lelbc_iter_core: ROUNDS must be a multiple of UNROLL");
    end
    if ((1 << CNT_W) < ROUNDS) begin : g_bad_cnt
        $error("lelbc_iter_core: CNT_W too narrow for ROUNDS");
    end

    // Terminal compare is one bit wider so ROUNDS == 2**CNT_W never needs the counter to wrap.
    localparam logic [CNT_W:0]   LAST_C = (CNT_W+1)'(ROUNDS);
    localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(UNROLL);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(UNROLL);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] blk_q, blk_res;
    logic [KEY_W-1:0]   key_q, key_res;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_step;
    logic               abort_req;

`ifdef LELBC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Round chain; each stage's key is advanced using its absolute round index.
    for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
        logic [BLOCK_W-1:0] bi, bo;
        logic [KEY_W-1:0]   ki, ko;
        if (j == 0) begin : g_first
            assign bi = blk_q;
            assign ki = key_q;
        end else begin : g_next
            assign bi = g_rnd[j-1].bo;
            assign ki = g_rnd[j-1].ko;
        end
        lelbc_round u_round (
            .x (bi),
            .k (ki[127:64]),
            .y (bo)
        );
        assign ko = key_next(ki, 5'(int'(cnt_q) + j));
    end

    assign blk_res   = g_rnd[UNROLL-1].bo;
    assign key_res   = g_rnd[UNROLL-1].ko;
    assign last_step = ({1'b0, cnt_q} + STEP_W) == LAST_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort_req)      state_d = ST_IDLE;
                else if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Abort wins over a simultaneous output transfer.
                if (abort_req || out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q     <= '0;
            key_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk_q <= in_data;
                        key_q <= in_key;
                        cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (!abort_req) begin
                        if (last_step) begin
                            out_data  <= blk_res;
                            out_valid <= 1'b1;
                        end else begin
                            blk_q <= blk_res;
                            key_q <= key_res;
                            cnt_q <= cnt_q + STEP_C;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort_req || out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lelbc_iter_core.sv
// Bench for lelbc_iter_core: three instances (32 rounds x1, 32 rounds x4, 1 round x1)
// driven with random blocks; a scoreboard per instance checks data and latency.
`timescale 1ns/1ps
module tb_lelbc_iter_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_iv = 0, a_ir, a_ov, a_or = 1, a_busy;
    logic [63:0]  a_id = '0, a_od;
    logic [127:0] a_ik = '0;
    logic         b_iv = 0, b_ir, b_ov, b_or = 1, b_busy;
    logic [63:0]  b_id = '0, b_od;
    logic [127:0] b_ik = '0;
    logic         c_iv = 0, c_ir, c_ov, c_or = 1, c_busy;
    logic [63:0]  c_id = '0, c_od;
    logic [127:0] c_ik = '0;
`ifdef LELBC_ABORT_EN
    logic         a_abort = 0;
`endif

    lelbc_iter_core #(.ROUNDS(32), .UNROLL(1), .CNT_W(5)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_key(a_ik),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
`ifdef LELBC_ABORT_EN
        .abort(a_abort),
`endif
        .busy(a_busy));

    lelbc_iter_core #(.ROUNDS(32), .UNROLL(4), .CNT_W(5)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_key(b_ik),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
`ifdef LELBC_ABORT_EN
        .abort(1'b0),
`endif
        .busy(b_busy));

    lelbc_iter_core #(.ROUNDS(1), .UNROLL(1), .CNT_W(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_key(c_ik),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
`ifdef LELBC_ABORT_EN
        .abort(1'b0),
`endif
        .busy(c_busy));

    // ---------------- reference model (label bit 0 = vector MSB) ----------------
    function automatic logic [3:0] sb(input logic [3:0] n);
        logic [3:0] t [16];
        t = '{4'hC, 4'hE, 4'h6, 4'hA, 4'h4, 4'hF, 4'h2, 4'h7,
              4'h9, 4'h8, 4'h3, 4'hB, 4'h0, 4'hD, 4'h1, 4'h5};
        return t[n];
    endfunction

    function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [63:0] model(input logic [63:0] x, input logic [127:0] k, input int rounds);
        logic [31:0] a, b, c, d;
        logic [63:0] s;
        for (int i = 0; i < rounds; i++) begin
            a = x[63:32] ^ k[127:96];
            b = rol32(a, 5) ^ x[31:0];
            s = {a, b};
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
            c = s[63:32] ^ rol32(s[31:0], 5);
            d = s[31:0] ^ k[95:64];
            x = {c, d};
            k = (k << 61) | (k >> 67);
            k[127:124] = sb(k[127:124]);
            k = k ^ (128'(i % 32) << 64);
        end
        return x;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] d;
        int          acc;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    bit   a_seen = 0, b_seen = 0, c_seen = 0;
    int   checks = 0, errors = 0;

    function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, req, $time);
        end
    endfunction

    function automatic void unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: output valid with empty scoreboard, required none (t=%0t)", nm, $time);
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (a_ov && !a_seen) begin
            a_seen = 1;
            if (q_a.size() == 0) unexpected("a_unexpected");
            else chk("a_latency", 128'(cyc - q_a[0].acc), 128'(32));
        end
        if (a_ov && a_or) begin
            if (q_a.size() != 0) begin chk("a_data", a_od, q_a[0].d); void'(q_a.pop_front()); end
            a_seen = 0;
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (b_ov && !b_seen) begin
            b_seen = 1;
            if (q_b.size() == 0) unexpected("b_unexpected");
            else chk("b_latency", 128'(cyc - q_b[0].acc), 128'(8));
        end
        if (b_ov && b_or) begin
            if (q_b.size() != 0) begin chk("b_data", b_od, q_b[0].d); void'(q_b.pop_front()); end
            b_seen = 0;
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (c_ov && !c_seen) begin
            c_seen = 1;
            if (q_c.size() == 0) unexpected("c_unexpected");
            else chk("c_latency", 128'(cyc - q_c[0].acc), 128'(1));
        end
        if (c_ov && c_or) begin
            if (q_c.size() != 0) begin chk("c_data", c_od, q_c[0].d); void'(q_c.pop_front()); end
            c_seen = 0;
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic drive(input int u, input logic v, input logic [63:0] d, input logic [127:0] k);
        case (u)
            0:       begin a_iv = v; a_id = d; a_ik = k; end
            1:       begin b_iv = v; b_id = d; b_ik = k; end
            default: begin c_iv = v; c_id = d; c_ik = k; end
        endcase
    endtask

    function automatic logic rdy(input int u);
        case (u)
            0:       return a_ir;
            1:       return b_ir;
            default: return c_ir;
        endcase
    endfunction

    function automatic logic bsy(input int u);
        case (u)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int u, input logic [63:0] d, input logic [127:0] k);
        int   budget;
        exp_t e;
        budget = 200;
        drive(u, 1'b1, d, k);
        while (!rdy(u) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout u=%0d: in_ready stayed 0, required 1", u);
            drive(u, 1'b0, r64(), r128());
        end else begin
            e.d   = model(d, k, (u == 2) ? 1 : 32);
            e.acc = cyc + 1;
            case (u)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
            @(posedge clk); #1;
            drive(u, 1'b0, r64(), r128());
            chk($sformatf("busy_after_accept_u%0d", u), 128'(bsy(u)), 128'(1));
            chk($sformatf("in_ready_in_run_u%0d", u), 128'(rdy(u)), 128'(0));
        end
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk(nm, 128'(q_a.size() + q_b.size() + q_c.size()), 128'(0));
    endtask

    task automatic check_reset_a(input string nm);
        chk({nm, "_ov"},   128'(a_ov),   128'(0));
        chk({nm, "_od"},   a_od,         128'(0));
        chk({nm, "_busy"}, 128'(a_busy), 128'(0));
        chk({nm, "_ir"},   128'(a_ir),   128'(1));
    endtask

    logic [63:0]  pd [6];
    logic [127:0] pk [6];
    logic [63:0]  e_stall;
    logic [63:0]  sd;
    logic [127:0] sk;
    bit           stream_done;

    initial begin
        #1;
        check_reset_a("reset_held");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_a("reset_released");

        // Single round, all-zero block and key.
        send(2, 64'h0, 128'h0);
        @(posedge clk); #1;
        chk("c_zero_vec_valid", 128'(c_ov), 128'(1));
        chk("c_zero_vec_data", c_od, 128'(64'h5555_5555_CCCC_CCCC));
        for (int i = 0; i < 4; i++) send(2, r64(), r128());
        drain("drain_c");

        // Same random blocks through the x1 and x4 instances.
        for (int i = 0; i < 6; i++) begin pd[i] = r64(); pk[i] = r128(); end
        fork
            begin for (int i = 0; i < 6; i++) send(0, pd[i], pk[i]); end
            begin for (int i = 0; i < 6; i++) send(1, pd[i], pk[i]); end
        join
        drain("drain_ab");

        // Random stream with random sink backpressure.
        stream_done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(0, r64(), r128());
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    a_or = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_or = 1'b1;
        drain("drain_stream");

        // Stall in DONE for 10 cycles while in_valid pulses with junk.
        a_or = 1'b0;
        sd = r64();
        sk = r128();
        e_stall = model(sd, sk, 32);
        send(0, sd, sk);
        for (int t = 0; t < 100 && !a_ov; t++) begin @(posedge clk); #1; end
        chk("stall_reach_done", 128'(a_ov), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a_iv = i[0];
            a_id = r64();
            a_ik = r128();
            chk("stall_ov", 128'(a_ov), 128'(1));
            chk("stall_od", a_od, 128'(e_stall));
            chk("stall_ir", 128'(a_ir), 128'(0));
            chk("stall_busy", 128'(a_busy), 128'(0));
        end
        a_iv = 1'b0;
        a_or = 1'b1;
        drain("drain_stall");

        // Reset in the middle of RUN, then a fresh block.
        send(0, r64(), r128());
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        q_a.delete();
        a_seen = 0;
        #1;
        check_reset_a("midrun_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        check_reset_a("midrun_release");
        send(0, r64(), r128());
        drain("drain_after_reset");

`ifdef LELBC_ABORT_EN
        send(0, r64(), r128());
        repeat (2) @(posedge clk);
        #1 a_abort = 1'b1;
        @(posedge clk); #1 a_abort = 1'b0;
        void'(q_a.pop_back());
        chk("abort_ir", 128'(a_ir), 128'(1));
        chk("abort_ov", 128'(a_ov), 128'(0));
        repeat (40) @(posedge clk);
        #1;
        send(0, r64(), r128());
        drain("drain_after_abort");
`endif

        @(posedge clk); #1;
        chk("final_idle_a", 128'(a_ir), 128'(1));
        chk("final_idle_b", 128'(b_ir), 128'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
